// File: rtl/pixel_deserializer.sv
// -----------------------------------------------------------------------------
// pixel_deserializer
//   Input front end of the MNIST CNN pipeline, directly upstream of
//   conv_layer_1. It assembles the serial data_in stream into PIXEL_W-bit
//   pixels, frames them into IMG_W x IMG_H images, and tags every pixel with
//   its row/col. frame_start/frame_done let conv1 align its line buffers to
//   pixel (0,0).
//
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        async active-low reset
//   data_in      in   1        serial pixel bit
//   bit_valid    in   1        qualifies data_in this cycle
//   frame_sync   in   1        1-cycle pulse, start of a new frame
//   pixel_out    out  PIXEL_W  assembled pixel (held between strobes)
//   pixel_valid  out  1        1-cycle strobe, pixel_out/row/col valid
//   row          out  ROW_W    row index of pixel_out
//   col          out  COL_W    col index of pixel_out
//   frame_start  out  1        with pixel_valid of pixel (0,0)
//   frame_done   out  1        with pixel_valid of the last pixel
//   frame_err    out  1        1-cycle pulse, frame aborted by early sync
//   busy         out  1        high while receiving a frame
// -----------------------------------------------------------------------------
module pixel_deserializer #(
    parameter int PIXEL_W   = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter bit MSB_FIRST = 1'b1,
    localparam int ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_in,
    input  logic               bit_valid,
    input  logic               frame_sync,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               pixel_valid,
    output logic [ROW_W-1:0]   row,
    output logic [COL_W-1:0]   col,
    output logic               frame_start,
    output logic               frame_done,
    output logic               frame_err,
    output logic               busy
);

    localparam int BIT_W = (PIXEL_W > 1) ? $clog2(PIXEL_W) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIXEL_W - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t state_q, state_d;

    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [COL_W-1:0]   col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
    logic [PIXEL_W-1:0] shift_q,   shift_d;

    logic [PIXEL_W-1:0] pixel_d;
    logic [ROW_W-1:0]   row_d;
    logic [COL_W-1:0]   col_d;
    logic               pixel_valid_d;
    logic               frame_start_d;
    logic               frame_done_d;
    logic               frame_err_d;

    // Counter/shift values the incoming bit builds on: the live registers, or
    // zero when a sync restarts the frame in this same cycle.
    logic [BIT_W-1:0]   bit_base;
    logic [COL_W-1:0]   col_base;
    logic [ROW_W-1:0]   row_base;
    logic [PIXEL_W-1:0] shift_base;
    logic [PIXEL_W-1:0] shift_in;
    logic               accept;

    assign busy = (state_q == RECV);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here is given a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        col_cnt_d     = col_cnt_q;
        row_cnt_d     = row_cnt_q;
        shift_d       = shift_q;
        pixel_d       = pixel_out;
        row_d         = row;
        col_d         = col;
        pixel_valid_d = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        bit_base      = bit_cnt_q;
        col_base      = col_cnt_q;
        row_base      = row_cnt_q;
        shift_base    = shift_q;
        shift_in      = '0;
        accept        = 1'b0;

        // A sync always restarts the frame, even on the last bit of the
        // current one; any partial pixel/frame is dropped.
        if (frame_sync) begin
            state_d     = RECV;
            frame_err_d = (state_q == RECV);
            bit_base    = '0;
            col_base    = '0;
            row_base    = '0;
            shift_base  = '0;
            bit_cnt_d   = '0;
            col_cnt_d   = '0;
            row_cnt_d   = '0;
            shift_d     = '0;
            accept      = bit_valid;
        end else if (state_q == RECV) begin
            accept = bit_valid;
        end

        if (MSB_FIRST) begin
            shift_in = {shift_base[PIXEL_W-2:0], data_in};
        end else begin
            shift_in = {data_in, shift_base[PIXEL_W-1:1]};
        end

        if (accept) begin
            if (bit_base == BIT_LAST) begin
                bit_cnt_d     = '0;
                shift_d       = '0;
                pixel_d       = shift_in;
                row_d         = row_base;
                col_d         = col_base;
                pixel_valid_d = 1'b1;
                frame_start_d = (row_base == '0) && (col_base == '0);
                if (col_base == COL_LAST) begin
                    col_cnt_d = '0;
                    if (row_base == ROW_LAST) begin
                        frame_done_d = 1'b1;
                        row_cnt_d    = '0;
                        state_d      = IDLE;
                    end else begin
                        row_cnt_d = row_base + 1'b1;
                    end
                end else begin
                    col_cnt_d = col_base + 1'b1;
                end
            end else begin
                bit_cnt_d = bit_base + 1'b1;
                shift_d   = shift_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            shift_q     <= '0;
            pixel_out   <= '0;
            row         <= '0;
            col         <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed before this edge, independent of statement order.
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            shift_q     <= shift_d;
            pixel_out   <= pixel_d;
            row         <= row_d;
            col         <= col_d;
            pixel_valid <= pixel_valid_d;
            frame_start <= frame_start_d;
            frame_done  <= frame_done_d;
            frame_err   <= frame_err_d;
        end
    end

endmodule
